// File: rtl/opcode_screen.sv
// Opcode legality screen: checks each accepted opcode against a programmable mask and forwards
// it through one registered valid/ready stage, keeping sticky error status for illegal opcodes.
module opcode_screen #(
  parameter int unsigned OP_WIDTH = 4,
  parameter logic [2**OP_WIDTH-1:0] DEFAULT_MASK = 16'h07EF,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [OP_WIDTH-1:0]    in_op,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OP_WIDTH-1:0]    out_op,
  output logic                   out_illegal,
  input  logic                   drop_illegal,
  input  logic                   cfg_we,
  input  logic [2**OP_WIDTH-1:0] cfg_mask,
  input  logic                   err_clr,
  output logic                   err_sticky,
  output logic [CNT_WIDTH-1:0]   err_count,
  output logic [OP_WIDTH-1:0]    err_last_op
);

  localparam int unsigned MaskWidth = 2**OP_WIDTH;

  logic [MaskWidth-1:0] mask_q;
  logic                 out_valid_q, out_valid_d;
  logic [OP_WIDTH-1:0]  out_op_q;
  logic                 out_illegal_q;
  logic                 err_sticky_q, err_sticky_d;
  logic [CNT_WIDTH-1:0] err_count_q, err_count_d, count_inc;
  logic [OP_WIDTH-1:0]  err_last_op_q;

  logic accept;
  logic op_illegal;
  logic load;
  logic illegal_accept;

  assign in_ready       = ~out_valid_q | out_ready;
  assign accept         = in_valid & in_ready;
  // Checked against the mask as it stands before any same-cycle cfg_we write.
  assign op_illegal     = ~mask_q[in_op];
  assign load           = accept & ~(op_illegal & drop_illegal);
  assign illegal_accept = accept & op_illegal;

  always_comb begin
    out_valid_d = out_valid_q & ~out_ready;
    if (load) begin
      out_valid_d = 1'b1;
    end
  end

  always_comb begin
    count_inc = (err_count_q == {CNT_WIDTH{1'b1}}) ? err_count_q
                                                  : err_count_q + CNT_WIDTH'(1);
    err_count_d  = err_count_q;
    err_sticky_d = err_sticky_q;
    // A same-cycle clear loses to the illegal accept, which then counts from zero.
    if (illegal_accept) begin
      err_sticky_d = 1'b1;
      err_count_d  = err_clr ? CNT_WIDTH'(1) : count_inc;
    end else if (err_clr) begin
      err_sticky_d = 1'b0;
      err_count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      out_op_q      <= '0;
      out_illegal_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      if (load) begin
        out_op_q      <= in_op;
        out_illegal_q <= op_illegal;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky_q  <= 1'b0;
      err_count_q   <= '0;
      err_last_op_q <= '0;
    end else begin
      err_sticky_q <= err_sticky_d;
      err_count_q  <= err_count_d;
      if (illegal_accept) begin
        err_last_op_q <= in_op;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= DEFAULT_MASK;
    end else if (cfg_we) begin
      mask_q <= cfg_mask;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_op      = out_op_q;
  assign out_illegal = out_illegal_q;
  assign err_sticky  = err_sticky_q;
  assign err_count   = err_count_q;
  assign err_last_op = err_last_op_q;

endmodule

// File: tb/tb_opcode_screen.sv
// Bench for opcode_screen: table-driven reset-default stream, directed corner sequences and a
// randomized run, all checked against a behavioural model; a CNT_WIDTH=2 twin covers saturation.
module tb_opcode_screen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready, in_ready_s;
  logic [3:0]  in_op;
  logic        out_valid, out_valid_s;
  logic        out_ready;
  logic [3:0]  out_op, out_op_s;
  logic        out_illegal, out_illegal_s;
  logic        drop_illegal;
  logic        cfg_we;
  logic [15:0] cfg_mask;
  logic        err_clr;
  logic        err_sticky, err_sticky_s;
  logic [7:0]  err_count;
  logic [1:0]  err_count_s;
  logic [3:0]  err_last_op, err_last_op_s;

  always #5 clk = ~clk;

  opcode_screen #(.OP_WIDTH(4), .DEFAULT_MASK(16'h07EF), .CNT_WIDTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_illegal(out_illegal),
    .drop_illegal(drop_illegal), .cfg_we(cfg_we), .cfg_mask(cfg_mask), .err_clr(err_clr),
    .err_sticky(err_sticky), .err_count(err_count), .err_last_op(err_last_op)
  );

  opcode_screen #(.OP_WIDTH(4), .DEFAULT_MASK(16'h07EF), .CNT_WIDTH(2)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s), .in_op(in_op),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_op(out_op_s),
    .out_illegal(out_illegal_s), .drop_illegal(drop_illegal), .cfg_we(cfg_we),
    .cfg_mask(cfg_mask), .err_clr(err_clr), .err_sticky(err_sticky_s),
    .err_count(err_count_s), .err_last_op(err_last_op_s)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: one output slot, the mask as a bit set, an unbounded illegal tally.
  bit        m_valid;
  bit [3:0]  m_op;
  bit        m_ill;
  bit [15:0] m_mask;
  bit        m_sticky;
  int        m_cnt;
  bit [3:0]  m_last;

  typedef struct {
    bit       vld;
    bit [3:0] op;
    bit       exp_valid;
    bit [3:0] exp_op;
    bit       exp_ill;
    int       exp_cnt;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic model_reset();
    m_valid  = 0;
    m_op     = 0;
    m_ill    = 0;
    m_mask   = 16'h07EF;
    m_sticky = 0;
    m_cnt    = 0;
    m_last   = 0;
  endtask

  task automatic set_in(input bit vld, input bit [3:0] op, input bit ordy, input bit drop);
    in_valid     = vld;
    in_op        = op;
    out_ready    = ordy;
    drop_illegal = drop;
  endtask

  task automatic compare_all();
    chk("out_valid", out_valid, m_valid);
    chk("out_op", out_op, m_op);
    chk("out_illegal", out_illegal, m_ill);
    chk("err_sticky", err_sticky, m_sticky);
    chk("err_count", err_count, sat(m_cnt, 255));
    chk("err_last_op", err_last_op, m_last);
    chk("sat_out_valid", out_valid_s, m_valid);
    chk("sat_err_count", err_count_s, sat(m_cnt, 3));
  endtask

  // Called at posedge+1 with inputs set; returns at the next posedge+1 after checking.
  task automatic do_cycle();
    bit rdy, acc, ill;
    #2;
    rdy = !m_valid || out_ready;
    chk("in_ready", in_ready, rdy);
    acc = in_valid && rdy;
    ill = !m_mask[in_op];
    @(posedge clk);
    #1;
    if (acc && !(ill && drop_illegal)) begin
      m_valid = 1;
      m_op    = in_op;
      m_ill   = ill;
    end else if (out_ready) begin
      m_valid = 0;
    end
    if (acc && ill) begin
      m_sticky = 1;
      m_last   = in_op;
      m_cnt    = (err_clr ? 0 : m_cnt) + 1;
    end else if (err_clr) begin
      m_sticky = 0;
      m_cnt    = 0;
    end
    if (cfg_we) m_mask = cfg_mask;
    compare_all();
  endtask

  initial begin
    int cnt;
    rst_n    = 1'b0;
    cfg_we   = 1'b0;
    cfg_mask = '0;
    err_clr  = 1'b0;
    set_in(0, 0, 0, 0);
    model_reset();

    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      bit ill;
      ill = (i == 4) || (i >= 11);
      cnt += int'(ill);
      vecs[i].vld       = 1;
      vecs[i].op        = 4'(i);
      vecs[i].exp_valid = 1;
      vecs[i].exp_op    = 4'(i);
      vecs[i].exp_ill   = ill;
      vecs[i].exp_cnt   = cnt;
    end

    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    compare_all();

    // Reset-default stream 0..15.
    for (int i = 0; i < 16; i++) begin
      set_in(vecs[i].vld, vecs[i].op, 1, 0);
      do_cycle();
      chk("tbl_valid", out_valid, vecs[i].exp_valid);
      chk("tbl_op", out_op, vecs[i].exp_op);
      chk("tbl_illegal", out_illegal, vecs[i].exp_ill);
      chk("tbl_count", err_count, vecs[i].exp_cnt);
    end
    set_in(0, 0, 1, 0);
    do_cycle();
    chk("dflt_count", err_count, 6);
    chk("dflt_last", err_last_op, 15);
    chk("dflt_sticky", err_sticky, 1);

    // Drop mode: 3,4,5 -> 3, gap, 5.
    set_in(1, 3, 1, 1);
    do_cycle();
    chk("drop_v3", out_valid, 1);
    chk("drop_op3", out_op, 3);
    set_in(1, 4, 1, 1);
    do_cycle();
    chk("drop_gap", out_valid, 0);
    set_in(1, 5, 1, 1);
    do_cycle();
    chk("drop_v5", out_valid, 1);
    chk("drop_op5", out_op, 5);
    chk("drop_count", err_count, 7);
    chk("drop_last", err_last_op, 4);

    // Backpressure.
    set_in(1, 7, 1, 0);
    do_cycle();
    chk("bp_op7", out_op, 7);
    set_in(1, 8, 0, 0);
    repeat (5) begin
      do_cycle();
      chk("bp_in_ready", in_ready, 0);
      chk("bp_hold", out_op, 7);
    end
    set_in(1, 8, 1, 0);
    do_cycle();
    chk("bp_valid8", out_valid, 1);
    chk("bp_op8", out_op, 8);

    // Mask write races with an accept of 4.
    cfg_we   = 1'b1;
    cfg_mask = 16'h0010;
    set_in(1, 4, 1, 0);
    do_cycle();
    cfg_we = 1'b0;
    chk("mask_old", out_illegal, 1);
    do_cycle();
    chk("mask_new4", out_illegal, 0);
    set_in(1, 0, 1, 0);
    do_cycle();
    chk("mask_new0", out_illegal, 1);

    // Saturation and clear.
    err_clr = 1'b1;
    set_in(0, 0, 1, 0);
    do_cycle();
    err_clr = 1'b0;
    chk("clr_count", err_count, 0);
    set_in(1, 9, 1, 0);
    repeat (5) do_cycle();
    chk("sat_stuck", err_count_s, 3);
    chk("sat_full", err_count, 5);
    err_clr = 1'b1;
    set_in(1, 12, 1, 0);
    do_cycle();
    chk("clr_win_cnt", err_count_s, 1);
    chk("clr_win_sticky", err_sticky_s, 1);
    set_in(0, 0, 1, 0);
    do_cycle();
    err_clr = 1'b0;
    chk("clr_cnt", err_count_s, 0);
    chk("clr_sticky", err_sticky_s, 0);
    chk("clr_last", err_last_op_s, 12);

    // Randomized run.
    for (int i = 0; i < 600; i++) begin
      set_in(($urandom_range(0, 3) != 0), 4'($urandom), ($urandom_range(0, 3) != 0),
             1'($urandom));
      cfg_we   = ($urandom_range(0, 15) == 0);
      cfg_mask = 16'($urandom);
      err_clr  = ($urandom_range(0, 19) == 0);
      do_cycle();
    end
    cfg_we  = 1'b0;
    err_clr = 1'b0;

    // Asynchronous reset while stalled.
    set_in(0, 0, 1, 0);
    do_cycle();
    set_in(1, 6, 0, 0);
    do_cycle();
    set_in(0, 0, 0, 0);
    do_cycle();
    chk("ar_pre_valid", out_valid, 1);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("ar_valid", out_valid, 0);
    chk("ar_in_ready", in_ready, 1);
    chk("ar_op", out_op, 0);
    chk("ar_count", err_count, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_cycle();
    chk("ar_no_replay", out_valid, 0);
    set_in(1, 4, 1, 0);
    do_cycle();
    chk("ar_mask4", out_illegal, 1);
    set_in(1, 5, 1, 0);
    do_cycle();
    chk("ar_mask5", out_illegal, 0);
    set_in(1, 11, 1, 0);
    do_cycle();
    chk("ar_mask11", out_illegal, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
